// File: rtl/alu_exec_ctrl_if.sv
// Instruction handshake between the decode stage and the ALU execute controller.
// The master side (decode) presents a decoded instruction; the slave accepts it on valid & ready.
interface alu_exec_ctrl_if #(
    parameter int unsigned REG_AW = 4
);
    logic              valid;
    logic              ready;
    logic [7:0]        op;
    logic [REG_AW-1:0] rdest;
    logic [REG_AW-1:0] rsrc;
    logic [7:0]        imm;

    modport master (output valid, op, rdest, rsrc, imm, input ready);
    modport slave  (input valid, op, rdest, rsrc, imm, output ready);
endinterface

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle sequencer for the 16-bit ALU: IDLE->READ->EXEC->WB. It reads the regfile,
// drives the ALU, writes the result back and holds the PSR flags.
module alu_exec_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned FLAG_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    alu_exec_ctrl_if.slave    instr,
    output logic [REG_AW-1:0] rf_raddr_a,
    output logic [REG_AW-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [7:0]        alu_opcode,
    output logic              alu_carry_in,
    input  logic [DATA_W-1:0] alu_c,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic [FLAG_W-1:0] psr_flags,
    output logic              done,
    output logic              illegal
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t              state_q, state_d;
    logic [7:0]          op_q;
    logic [7:0]          imm_q;
    logic [REG_AW-1:0]   rdest_q;
    logic                carry_q;
    logic [FLAG_W-1:0]   flags_q;
    logic                accept_c;

    function automatic logic is_sext_imm(input logic [7:0] op);
        return (op == 8'h50) || (op == 8'h70) || (op == 8'h90) || (op == 8'hB0);
    endfunction

    function automatic logic is_zext_imm(input logic [7:0] op);
        return (op == 8'h60) || (op == 8'h40) || (op == 8'h0C);
    endfunction

    function automatic logic is_shift_imm(input logic [7:0] op);
        return (op == 8'h80) || (op == 8'h81);
    endfunction

    function automatic logic is_carry_op(input logic [7:0] op);
        return (op == 8'h07) || (op == 8'h70) || (op == 8'h04) || (op == 8'h40);
    endfunction

    function automatic logic is_cmp(input logic [7:0] op);
        return (op == 8'h0B) || (op == 8'hB0) || (op == 8'h08) || (op == 8'h0C);
    endfunction

    // Arithmetic and compare ops are the only ones that load the PSR.
    function automatic logic sets_psr(input logic [7:0] op);
        case (op)
            8'h05, 8'h06, 8'h07, 8'h04, 8'h09, 8'h0B, 8'h08,
            8'h50, 8'h60, 8'h70, 8'h40, 8'h90, 8'hB0, 8'h0C: sets_psr = 1'b1;
            default:                                         sets_psr = 1'b0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [7:0] op);
        case (op)
            8'h01, 8'h02, 8'h03, 8'h0F, 8'h84, 8'h85, 8'h86, 8'h87,
            8'h80, 8'h81: is_legal = 1'b1;
            default:      is_legal = sets_psr(op);
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] operand_b(input logic [7:0] op,
                                                     input logic [7:0] imm,
                                                     input logic [DATA_W-1:0] rdata);
        if (is_sext_imm(op))
            operand_b = {{(DATA_W-8){imm[7]}}, imm};
        else if (is_zext_imm(op))
            operand_b = {{(DATA_W-8){1'b0}}, imm};
        else if (is_shift_imm(op))
            operand_b = {{(DATA_W-4){1'b0}}, imm[3:0]};
        else
            operand_b = rdata;
    endfunction

    assign instr.ready = (state_q == IDLE);
    assign accept_c    = instr.valid && (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state; the ALU inputs are live only during EXEC, when regfile data is valid.
    always_comb begin
        state_d      = state_q;
        alu_a        = '0;
        alu_b        = '0;
        alu_opcode   = '0;
        alu_carry_in = 1'b0;
        case (state_q)
            IDLE: if (accept_c) state_d = READ;
            READ: state_d = EXEC;
            EXEC: begin
                state_d      = WB;
                alu_a        = rf_rdata_a;
                alu_b        = operand_b(op_q, imm_q, rf_rdata_b);
                alu_opcode   = op_q;
                alu_carry_in = carry_q;
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= '0;
            imm_q      <= '0;
            rdest_q    <= '0;
            carry_q    <= 1'b0;
            flags_q    <= '0;
            rf_raddr_a <= '0;
            rf_raddr_b <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            psr_flags  <= '0;
            done       <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            rf_we   <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state_q)
                IDLE: if (accept_c) begin
                    op_q       <= instr.op;
                    imm_q      <= instr.imm;
                    rdest_q    <= instr.rdest;
                    carry_q    <= psr_flags[3] && is_carry_op(instr.op);
                    rf_raddr_a <= instr.rdest;
                    rf_raddr_b <= instr.rsrc;
                end
                // Capture the ALU result; WB presents it with the write pulse.
                EXEC: begin
                    flags_q  <= alu_flags;
                    rf_we    <= is_legal(op_q) && !is_cmp(op_q);
                    rf_waddr <= rdest_q;
                    rf_wdata <= alu_c;
                    done     <= 1'b1;
                    illegal  <= !is_legal(op_q);
                end
                WB: if (sets_psr(op_q)) psr_flags <= flags_q;
                default: ;
            endcase
        end
    end
endmodule
